// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter: two level-held requests in, one ack/err pulse
// and the pop result out.
interface stack_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic             ack0;
    logic             ack1;
    logic             err0;
    logic             err1;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req0, req1, op0, op1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata
    );

    modport slave (
        input  req0, req1, op0, op1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter serialising push/pop requests from two requesters onto one external
// stack; one operation every three cycles (IDLE -> EXEC -> ACK).
module stack_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned HEIGHT     = 9,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_arbiter_if.slave        bus,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH-1:0]      stk_data_in,
    input  logic [WIDTH-1:0]      stk_data_out,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH-1:0] HEIGHT_C = ADDR_WIDTH'(HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ONE_C    = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   count_q;
    logic                    last_q;
    logic                    win_q;
    logic                    err_flag_q;
    logic                    ack0_q;
    logic                    ack1_q;
    logic                    err0_q;
    logic                    err1_q;
    logic [WIDTH-1:0]        rdata_q;
    logic                    stk_push_q;
    logic                    stk_pop_q;
    logic [WIDTH-1:0]        stk_data_in_q;

    logic                    win_c;
    logic                    sel_op_c;
    logic [WIDTH-1:0]        sel_wdata_c;

    // A tie goes to the requester that was not granted last.
    always_comb begin
        win_c = bus.req1;
        if (bus.req0 && bus.req1) begin
            win_c = ~last_q;
        end
        sel_op_c    = win_c ? bus.op1 : bus.op0;
        sel_wdata_c = win_c ? bus.wdata1 : bus.wdata0;
    end

    assign full  = (count_q == HEIGHT_C);
    assign empty = (count_q == '0);

    // The push/pop decision is taken when the request is latched, so the strobes are
    // already registered and valid for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            last_q        <= 1'b1;
            win_q         <= 1'b0;
            err_flag_q    <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rdata_q       <= '0;
            stk_push_q    <= 1'b0;
            stk_pop_q     <= 1'b0;
            stk_data_in_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win_q <= win_c;
                        if (!sel_op_c) begin
                            stk_push_q    <= ~full;
                            stk_data_in_q <= full ? '0 : sel_wdata_c;
                            err_flag_q    <= full;
                        end else begin
                            stk_pop_q     <= ~empty;
                            err_flag_q    <= empty;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    stk_push_q    <= 1'b0;
                    stk_pop_q     <= 1'b0;
                    stk_data_in_q <= '0;
                    if (stk_push_q) begin
                        count_q <= count_q + ONE_C;
                    end else if (stk_pop_q) begin
                        count_q <= count_q - ONE_C;
                    end
                    // Top of stack is sampled before the pop takes effect.
                    rdata_q <= stk_pop_q ? stk_data_out : '0;
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                    err0_q  <= ~win_q & err_flag_q;
                    err1_q  <= win_q & err_flag_q;
                    state_q <= ACK;
                end
                ACK: begin
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    err0_q     <= 1'b0;
                    err1_q     <= 1'b0;
                    rdata_q    <= '0;
                    err_flag_q <= 1'b0;
                    last_q     <= win_q;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata   = rdata_q;
    assign stk_push    = stk_push_q;
    assign stk_pop     = stk_pop_q;
    assign stk_data_in = stk_data_in_q;
    assign count       = count_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed sequences followed by random traffic, checked against a
// transaction-level model (queue-based stack, round-robin grant, 3-cycle slots).
module tb_stack_arbiter;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 9;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stk_push;
    logic          stk_pop;
    logic          full;
    logic          empty;
    logic [W-1:0]  stk_data_in;
    logic [W-1:0]  stk_data_out;
    logic [AW-1:0] count;

    stack_arbiter_if #(.WIDTH(W)) bus ();

    stack_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    // Attached stack device, reset together with the arbiter.
    logic [W-1:0] mem [16];
    logic [4:0]   sp;
    logic [4:0]   spm1;
    always @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (stk_push && sp < 5'd16) begin
            mem[sp[3:0]] <= stk_data_in;
            sp           <= sp + 5'd1;
        end else if (stk_pop && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end
    assign spm1         = sp - 5'd1;
    assign stk_data_out = (sp != 5'd0) ? mem[spm1[3:0]] : '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model state
    logic [W-1:0] mstk [$];
    int           last_g       = 1;
    int           busy         = 0;
    int           w_win        = 0;
    logic         w_op         = 1'b0;
    logic [W-1:0] w_data       = '0;
    logic         exp_err      = 1'b0;
    logic [W-1:0] exp_rdata    = '0;
    int           cyc          = 0;
    int           last_ack_cyc = -100;
    int           ack_seen     = -1;
    int           push_pct     = 50;
    logic         r_req [2];
    logic         r_op  [2];
    logic [W-1:0] r_wd  [2];

    task automatic new_op(input int i);
        r_req[i] = 1'b1;
        r_op[i]  = ($urandom_range(0, 99) >= push_pct);
        r_wd[i]  = W'($urandom);
    endtask

    // One clock: sample/check outputs at negedge, then drive the next inputs.
    task automatic step(input bit do_rst, input bit rnd);
        logic a [2];
        logic e [2];
        @(negedge clk);
        cyc++;
        ack_seen = -1;
        a[0] = bus.ack0;
        a[1] = bus.ack1;
        e[0] = bus.err0;
        e[1] = bus.err1;
        chk("strobe_excl", 32'(stk_push & stk_pop), 0);
        if (busy == 3) begin
            chk("exec_push", 32'(stk_push), 32'(w_op == 1'b0 && !exp_err));
            chk("exec_pop", 32'(stk_pop), 32'(w_op == 1'b1 && !exp_err));
            if (w_op == 1'b0 && !exp_err) chk("exec_wdata", 32'(stk_data_in), 32'(w_data));
            chk("exec_noack", 32'({a[1], a[0]}), 0);
            chk("exec_count", 32'(count), mstk.size());
            if (!exp_err) begin
                if (w_op) void'(mstk.pop_back());
                else mstk.push_back(w_data);
            end
        end else if (busy == 2) begin
            chk("ack_win", 32'(a[w_win]), 1);
            chk("ack_other", 32'(a[1-w_win]), 0);
            chk("err", 32'(e[w_win]), 32'(exp_err));
            chk("err_other", 32'(e[1-w_win]), 0);
            chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
            chk("ack_gap", 32'(cyc - last_ack_cyc >= 3), 1);
            last_ack_cyc = cyc;
            last_g       = w_win;
            ack_seen     = w_win;
        end else begin
            chk("idle_ack", 32'({a[1], a[0]}), 0);
            chk("idle_strobe", 32'({stk_push, stk_pop}), 0);
        end
        if (busy != 3) begin
            chk("count", 32'(count), mstk.size());
            chk("full", 32'(full), 32'(mstk.size() == H));
            chk("empty", 32'(empty), 32'(mstk.size() == 0));
        end
        if (busy > 0) busy--;

        for (int i = 0; i < 2; i++) begin
            if (ack_seen == i) begin
                if (rnd && $urandom_range(0, 99) < 60) new_op(i);
                else r_req[i] = 1'b0;
            end else if (rnd && !r_req[i] && $urandom_range(0, 99) < 30) begin
                new_op(i);
            end
        end
        rst        = do_rst;
        bus.req0   = r_req[0];
        bus.req1   = r_req[1];
        bus.op0    = r_op[0];
        bus.op1    = r_op[1];
        bus.wdata0 = r_wd[0];
        bus.wdata1 = r_wd[1];

        if (do_rst) begin
            mstk.delete();
            last_g = 1;
            busy   = 0;
        end else if (busy == 0 && (r_req[0] || r_req[1])) begin
            if (r_req[0] && r_req[1]) w_win = 1 - last_g;
            else w_win = r_req[1] ? 1 : 0;
            w_op   = r_op[w_win];
            w_data = r_wd[w_win];
            if (!w_op) begin
                exp_err   = (mstk.size() == H);
                exp_rdata = '0;
            end else begin
                exp_err   = (mstk.size() == 0);
                exp_rdata = exp_err ? '0 : mstk[$];
            end
            busy = 3;
        end
    endtask

    task automatic do_op(input int who, input logic op, input logic [W-1:0] d);
        int n;
        n           = 0;
        r_req[who]  = 1'b1;
        r_op[who]   = op;
        r_wd[who]   = d;
        while (r_req[who] && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("op_done", 32'(r_req[who]), 0);
        r_req[who] = 1'b0;
    endtask

    initial begin
        int alt_idx;
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0;
            r_op[i]  = 1'b0;
            r_wd[i]  = '0;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_rdata", 32'(bus.rdata), 0);
        chk("rst_err", 32'({bus.err1, bus.err0}), 0);
        chk("rst_din", 32'(stk_data_in), 0);

        // Single push, then a pop back, then LIFO order of two pushes
        do_op(0, 1'b0, 8'hA5);
        do_op(1, 1'b1, 8'h00);
        do_op(0, 1'b0, 8'h11);
        do_op(0, 1'b0, 8'h22);
        do_op(1, 1'b1, 8'h00);
        do_op(1, 1'b1, 8'h00);
        do_op(1, 1'b1, 8'h00);

        // Both requesters held high pushing: grants alternate and the stack fills up
        r_req[0] = 1'b1; r_op[0] = 1'b0; r_wd[0] = 8'h30;
        r_req[1] = 1'b1; r_op[1] = 1'b0; r_wd[1] = 8'h40;
        alt_idx = 0;
        n = 0;
        while (alt_idx < 10 && n < 60) begin
            step(1'b0, 1'b0);
            n++;
            if (ack_seen >= 0) begin
                chk("alternate", ack_seen, alt_idx % 2);
                alt_idx++;
                r_req[ack_seen] = 1'b1;
                r_wd[ack_seen]  = W'(8'h30 + alt_idx);
            end
        end
        chk("alt_count", alt_idx, 10);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("full_after_fill", 32'(full), 1);

        // Reset in the EXEC cycle of a successful push
        do_op(1, 1'b1, 8'h00);
        r_req[0] = 1'b1; r_op[0] = 1'b0; r_wd[0] = 8'h5A;
        step(1'b0, 1'b0);
        r_req[0] = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_exec_count", 32'(count), 0);
        chk("rst_exec_noack", 32'({bus.ack1, bus.ack0}), 0);
        r_req[0] = 1'b1; r_op[0] = 1'b0; r_wd[0] = 8'h01;
        r_req[1] = 1'b1; r_op[1] = 1'b0; r_wd[1] = 8'h02;
        n = 0;
        ack_seen = -1;
        while (ack_seen < 0 && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("tie_after_rst", ack_seen, 0);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Random traffic with shifting push/pop mix and rare resets
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 3)
                0:       push_pct = 80;
                1:       push_pct = 20;
                default: push_pct = 50;
            endcase
            step($urandom_range(0, 399) == 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
